tile_ws_grid: RTL and testbench
===============================

TILE_WS_GRID -- requirements
Module: tile_ws_grid

Interface
REQ-001 Parameters, one per line (name, default, meaning):
  ROWS, 2, PE rows (1..16)
  COLS, 2, PE columns (1..16)
  A_W, 8, signed activation width
  B_W, 19, signed weight width
  D_W, dbits (32), signed partial-sum width
  SHIFT_W, 5, output shift width
REQ-002 One clock; reset is synchronous and active-high. Ports are named clock and reset.
REQ-003 Ports, one per line (name, direction, width, meaning):
  clock  in  1  clock
  reset  in  1  sync active-high reset
  io_in_a  in  ROWS*A_W  activation per row, enters left
  io_in_b  in  COLS*B_W  weight preload per column, enters top
  io_in_b_shift  in  COLS  weight-chain shift enable per column
  io_in_d  in  COLS*D_W  partial-sum input per column, enters top
  io_in_control_propagate  in  COLS  bank-select bit per column
  io_in_control_shift  in  COLS*SHIFT_W  output shift per column
  io_in_valid  in  COLS  column data valid
  io_out_a  out  ROWS*A_W  activation leaving right
  io_out_b  out  COLS*B_W  bottom-row shadow weight
  io_out_c  out  COLS*D_W  shifted result leaving bottom
  io_out_control_propagate  out  COLS  propagate, delayed
  io_out_control_shift  out  COLS*SHIFT_W  shift, delayed
  io_out_valid  out  COLS  result valid

Function
REQ-004 Each cell (r,c) SHALL hold weight banks W0 and W1, an active-bank index act, and last_prop. The shadow bank SHALL be W[~act].
REQ-005 Activation registers SHALL advance every cycle regardless of valid, one register per cell. io_out_a row r SHALL equal io_in_a row r delayed COLS cycles.
REQ-006 When io_in_b_shift[c]=1, in the same cycle, the column-c chain SHALL shift: shadow(0,c)<=io_in_b[c] and shadow(r,c)<=shadow(r-1,c). io_out_b[c] SHALL be shadow(ROWS-1,c) combinationally.
REQ-007 When a cell's incoming valid=1 and incoming propagate!=last_prop, the cell SHALL flip act and update last_prop. That cycle's compute SHALL use the new act.
REQ-008 On a cell's valid cycle, psum_out SHALL be registered as psum_in + a*W[act]. The product is signed and sign-extended; the sum wraps mod 2^D_W.
REQ-009 On a cell's valid cycle, valid, propagate and shift SHALL be registered down one row alongside psum.
REQ-010 When a cell's valid=0, its psum, propagate and shift registers SHALL hold, and its valid-out SHALL register 0. Weights and act SHALL be unchanged except by REQ-006.
REQ-011 Latency from io_in_valid[c] to io_out_valid[c] SHALL be exactly ROWS cycles. Input skew across rows and columns is the feeder's responsibility.
REQ-012 Only the bottom row SHALL apply the shift: io_out_c = (psum + (s>0 ? 2^(s-1) : 0)) >>> s, arithmetic, wrapping, with s clamped to D_W-1.
REQ-013 If a flip (REQ-007) and a chain shift (REQ-006) hit the same cell in the same cycle, the flip SHALL take effect first, then the chain SHALL write the new shadow bank.

Reset
REQ-014 On reset, all weights, act, last_prop, psum, activation, control and valid registers SHALL become 0 on the next edge. All outputs SHALL be 0 after that edge.
REQ-015 Reset asserted mid-operation SHALL discard in-flight data; no output SHALL be valid until new inputs have traversed the full ROWS-cycle latency.

Structure
REQ-016 A_W, B_W, D_W and SHIFT_W defaults and the rounding-shift function SHALL live in the shared tile parameters package.
REQ-017 One sub-module, pe_ws_cell, SHALL implement one cell. tile_ws_grid SHALL generate the ROWS x COLS array and the bottom-row shift.

Verification
REQ-018 Reset: assert reset one cycle with random inputs -> every output is 0 the following cycle.
REQ-019 Preload/compute, 2x2, column 0:
  - shift in b=3, then b=5 -> io_out_b[0]=3.
  - valid, prop=1, d=10, a row0=2 -> cell(0,0) psum=20.
  - next cycle a row1=-1 -> io_out_c[0]=17 with io_out_valid[0]=1 at ROWS=2 cycles.
REQ-020 Rounding shift: psum 17, s=2 -> 4; psum -6, s=2 -> -1; psum 2^31-1 plus product 1, s=0 -> -2^31.
REQ-021 Valid low: hold io_in_valid=0 for 5 cycles -> io_out_c and control hold, io_out_valid=0, io_out_a still tracks io_in_a delayed COLS cycles.
REQ-022 Simultaneous flip and shift in one cell -> the new active bank holds the pre-shift shadow value, and the new shadow holds the shifted-in value.
REQ-023 Reset mid-operation with a valid in flight -> no io_out_valid afterwards, and weights read back 0 via io_out_b.

Source files
------------

// File: rtl/tile_ws_grid_pkg.sv
// Shared tile parameters: default datapath widths and the bottom-row rounding shift.
package tile_ws_grid_pkg;

  localparam int unsigned TILE_A_W     = 8;
  localparam int unsigned TILE_B_W     = 19;
  localparam int unsigned TILE_D_W     = 32;
  localparam int unsigned TILE_SHIFT_W = 5;

  // Round-half-up arithmetic shift of a w-bit value carried in 64 bits; wraps mod 2^w.
  function automatic logic [63:0] round_shift(input logic [63:0] psum,
                                              input int unsigned s,
                                              input int unsigned w);
    int unsigned       sc;
    logic [63:0]       rnd;
    logic [63:0]       sum;
    logic signed [63:0] sext;
    sc   = (s > w - 1) ? w - 1 : s;
    rnd  = (sc > 0) ? (64'd1 << (sc - 1)) : 64'd0;
    sum  = psum + rnd;
    sext = $signed(sum << (64 - w)) >>> (64 - w);
    return sext >>> sc;
  endfunction

endpackage

// File: rtl/tile_ws_grid_pe_ws_cell.sv
// One weight-stationary PE: double-buffered weights, activation pass-through, psum accumulate.
module pe_ws_cell
  import tile_ws_grid_pkg::*;
#(
  parameter int unsigned A_W     = TILE_A_W,
  parameter int unsigned B_W     = TILE_B_W,
  parameter int unsigned D_W     = TILE_D_W,
  parameter int unsigned SHIFT_W = TILE_SHIFT_W
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [A_W-1:0]     i_a,
  input  logic [B_W-1:0]     i_b,
  input  logic               i_b_shift,
  input  logic [D_W-1:0]     i_d,
  input  logic               i_prop,
  input  logic [SHIFT_W-1:0] i_shift,
  input  logic               i_valid,
  output logic [A_W-1:0]     o_a,
  output logic [B_W-1:0]     o_b,
  output logic [D_W-1:0]     o_psum,
  output logic               o_prop,
  output logic [SHIFT_W-1:0] o_shift,
  output logic               o_valid
);

  localparam int unsigned P_W = (A_W + B_W > D_W) ? A_W + B_W : D_W;

  logic [B_W-1:0]     r_w0, r_w1;
  logic               r_act, r_last_prop;
  logic [A_W-1:0]     r_a;
  logic [D_W-1:0]     r_psum;
  logic               r_prop;
  logic [SHIFT_W-1:0] r_shift;
  logic               r_valid;

  logic               w_flip;
  logic               w_act;
  logic [B_W-1:0]     w_wt;
  logic signed [P_W-1:0] w_prod;
  logic [D_W-1:0]     w_sum;

  // A flip lands before the compute and before any chain write in the same cycle.
  assign w_flip = i_valid && (i_prop != r_last_prop);
  assign w_act  = r_act ^ w_flip;
  assign w_wt   = w_act ? r_w1 : r_w0;
  assign w_prod = P_W'($signed(i_a)) * P_W'($signed(w_wt));
  assign w_sum  = i_d + w_prod[D_W-1:0];

  always_ff @(posedge clock) begin
    if (reset) begin
      r_w0        <= '0;
      r_w1        <= '0;
      r_act       <= 1'b0;
      r_last_prop <= 1'b0;
      r_a         <= '0;
      r_psum      <= '0;
      r_prop      <= 1'b0;
      r_shift     <= '0;
      r_valid     <= 1'b0;
    end else begin
      r_a     <= i_a;
      r_valid <= i_valid;
      if (w_flip) begin
        r_act       <= w_act;
        r_last_prop <= i_prop;
      end
      if (i_valid) begin
        r_psum  <= w_sum;
        r_prop  <= i_prop;
        r_shift <= i_shift;
      end
      if (i_b_shift) begin
        if (w_act) r_w0 <= i_b;
        else       r_w1 <= i_b;
      end
    end
  end

  assign o_a     = r_a;
  assign o_b     = r_act ? r_w0 : r_w1;
  assign o_psum  = r_psum;
  assign o_prop  = r_prop;
  assign o_shift = r_shift;
  assign o_valid = r_valid;

endmodule

// File: rtl/tile_ws_grid.sv
// ROWS x COLS weight-stationary PE grid; activations flow right, psums and weights flow down.
module tile_ws_grid
  import tile_ws_grid_pkg::*;
#(
  parameter int unsigned ROWS    = 2,
  parameter int unsigned COLS    = 2,
  parameter int unsigned A_W     = TILE_A_W,
  parameter int unsigned B_W     = TILE_B_W,
  parameter int unsigned D_W     = TILE_D_W,
  parameter int unsigned SHIFT_W = TILE_SHIFT_W
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [ROWS*A_W-1:0]     io_in_a,
  input  logic [COLS*B_W-1:0]     io_in_b,
  input  logic [COLS-1:0]         io_in_b_shift,
  input  logic [COLS*D_W-1:0]     io_in_d,
  input  logic [COLS-1:0]         io_in_control_propagate,
  input  logic [COLS*SHIFT_W-1:0] io_in_control_shift,
  input  logic [COLS-1:0]         io_in_valid,
  output logic [ROWS*A_W-1:0]     io_out_a,
  output logic [COLS*B_W-1:0]     io_out_b,
  output logic [COLS*D_W-1:0]     io_out_c,
  output logic [COLS-1:0]         io_out_control_propagate,
  output logic [COLS*SHIFT_W-1:0] io_out_control_shift,
  output logic [COLS-1:0]         io_out_valid
);

  logic [A_W-1:0]     w_a     [ROWS][COLS+1];
  logic [B_W-1:0]     w_b     [ROWS+1][COLS];
  logic [D_W-1:0]     w_d     [ROWS+1][COLS];
  logic               w_prop  [ROWS+1][COLS];
  logic [SHIFT_W-1:0] w_shift [ROWS+1][COLS];
  logic               w_valid [ROWS+1][COLS];

  for (genvar r = 0; r < ROWS; r++) begin : g_row
    assign w_a[r][0]               = io_in_a[r*A_W +: A_W];
    assign io_out_a[r*A_W +: A_W]  = w_a[r][COLS];

    for (genvar c = 0; c < COLS; c++) begin : g_col
      pe_ws_cell #(
        .A_W    (A_W),
        .B_W    (B_W),
        .D_W    (D_W),
        .SHIFT_W(SHIFT_W)
      ) u_cell (
        .clock    (clock),
        .reset    (reset),
        .i_a      (w_a[r][c]),
        .i_b      (w_b[r][c]),
        .i_b_shift(io_in_b_shift[c]),
        .i_d      (w_d[r][c]),
        .i_prop   (w_prop[r][c]),
        .i_shift  (w_shift[r][c]),
        .i_valid  (w_valid[r][c]),
        .o_a      (w_a[r][c+1]),
        .o_b      (w_b[r+1][c]),
        .o_psum   (w_d[r+1][c]),
        .o_prop   (w_prop[r+1][c]),
        .o_shift  (w_shift[r+1][c]),
        .o_valid  (w_valid[r+1][c])
      );
    end
  end

  for (genvar c = 0; c < COLS; c++) begin : g_col_io
    assign w_b[0][c]     = io_in_b[c*B_W +: B_W];
    assign w_d[0][c]     = io_in_d[c*D_W +: D_W];
    assign w_prop[0][c]  = io_in_control_propagate[c];
    assign w_shift[0][c] = io_in_control_shift[c*SHIFT_W +: SHIFT_W];
    assign w_valid[0][c] = io_in_valid[c];

    // Only the bottom row applies the rounding shift.
    assign io_out_c[c*D_W +: D_W] =
      D_W'(round_shift(64'(w_d[ROWS][c]), 32'(w_shift[ROWS][c]), D_W));
    assign io_out_b[c*B_W +: B_W]                 = w_b[ROWS][c];
    assign io_out_control_propagate[c]            = w_prop[ROWS][c];
    assign io_out_control_shift[c*SHIFT_W +: SHIFT_W] = w_shift[ROWS][c];
    assign io_out_valid[c]                        = w_valid[ROWS][c];
  end

endmodule

// File: tb/tb_tile_ws_grid.sv
// Scoreboard bench for tile_ws_grid (2x2): directed vectors, monitor pops expected results.
module tb_tile_ws_grid;

  localparam int ROWS = 2;
  localparam int COLS = 2;
  localparam int A_W  = 8;
  localparam int B_W  = 19;
  localparam int D_W  = 32;
  localparam int SW   = 5;
  localparam int AT   = ROWS * A_W;
  localparam int BT   = COLS * B_W;
  localparam int DT   = COLS * D_W;
  localparam int ST   = COLS * SW;

  logic          clock;
  logic          reset;
  logic [AT-1:0] io_in_a;
  logic [BT-1:0] io_in_b;
  logic [COLS-1:0] io_in_b_shift;
  logic [DT-1:0] io_in_d;
  logic [COLS-1:0] io_in_control_propagate;
  logic [ST-1:0] io_in_control_shift;
  logic [COLS-1:0] io_in_valid;
  logic [AT-1:0] io_out_a;
  logic [BT-1:0] io_out_b;
  logic [DT-1:0] io_out_c;
  logic [COLS-1:0] io_out_control_propagate;
  logic [ST-1:0] io_out_control_shift;
  logic [COLS-1:0] io_out_valid;

  tile_ws_grid #(
    .ROWS(ROWS), .COLS(COLS), .A_W(A_W), .B_W(B_W), .D_W(D_W), .SHIFT_W(SW)
  ) dut (
    .clock                   (clock),
    .reset                   (reset),
    .io_in_a                 (io_in_a),
    .io_in_b                 (io_in_b),
    .io_in_b_shift           (io_in_b_shift),
    .io_in_d                 (io_in_d),
    .io_in_control_propagate (io_in_control_propagate),
    .io_in_control_shift     (io_in_control_shift),
    .io_in_valid             (io_in_valid),
    .io_out_a                (io_out_a),
    .io_out_b                (io_out_b),
    .io_out_c                (io_out_c),
    .io_out_control_propagate(io_out_control_propagate),
    .io_out_control_shift    (io_out_control_shift),
    .io_out_valid            (io_out_valid)
  );

  typedef struct {
    logic [D_W-1:0] c;
    int             cyc;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  int   n_vec = 0;
  int   n_err = 0;
  int   cyc   = 0;

  initial clock = 1'b0;
  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic expect_c(input int col, input logic [D_W-1:0] v);
    exp_t e;
    e.c   = v;
    e.cyc = cyc + ROWS;
    if (col == 0) q0.push_back(e);
    else          q1.push_back(e);
  endtask

  task automatic mon_col(input int col);
    exp_t e;
    int   sz;
    sz = (col == 0) ? q0.size() : q1.size();
    if (sz == 0) begin
      n_vec++;
      n_err++;
      $display("FAIL unexpected_valid col%0d: got valid=1 expected valid=0 (cycle %0d)", col, cyc);
    end else begin
      if (col == 0) e = q0.pop_front();
      else          e = q1.pop_front();
      check($sformatf("out_c col%0d", col), 64'(io_out_c[col*D_W +: D_W]), 64'(e.c));
      check($sformatf("latency col%0d", col), 64'(cyc), 64'(e.cyc));
    end
  endtask

  always @(negedge clock) begin
    if (io_out_valid[0] === 1'b1) mon_col(0);
    if (io_out_valid[1] === 1'b1) mon_col(1);
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle();
    io_in_a                 = '0;
    io_in_b                 = '0;
    io_in_b_shift           = '0;
    io_in_d                 = '0;
    io_in_control_propagate = '0;
    io_in_control_shift     = '0;
    io_in_valid             = '0;
  endtask

  task automatic set_a(input int row, input logic [A_W-1:0] v);
    io_in_a[row*A_W +: A_W] = v;
  endtask

  task automatic set_b(input int col, input logic [B_W-1:0] v);
    io_in_b[col*B_W +: B_W] = v;
  endtask

  task automatic drive_col(input int col, input logic v, input logic p,
                           input logic [D_W-1:0] d, input logic [SW-1:0] s);
    io_in_valid[col]                = v;
    io_in_control_propagate[col]    = p;
    io_in_d[col*D_W +: D_W]         = d;
    io_in_control_shift[col*SW +: SW] = s;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, " out_a"},     64'(io_out_a), 64'd0);
    check({tag, " out_b"},     64'(io_out_b), 64'd0);
    check({tag, " out_c"},     64'(io_out_c), 64'd0);
    check({tag, " out_prop"},  64'(io_out_control_propagate), 64'd0);
    check({tag, " out_shift"}, 64'(io_out_control_shift), 64'd0);
    check({tag, " out_valid"}, 64'(io_out_valid), 64'd0);
  endtask

  logic [AT-1:0] hist [5];

  initial begin
    // Reset with random inputs: everything reads zero after one edge.
    reset                   = 1'b1;
    io_in_a                 = AT'($urandom());
    io_in_b                 = BT'({$urandom(), $urandom()});
    io_in_b_shift           = COLS'($urandom());
    io_in_d                 = DT'({$urandom(), $urandom()});
    io_in_control_propagate = COLS'($urandom());
    io_in_control_shift     = ST'($urandom());
    io_in_valid             = COLS'($urandom());
    tick();
    check_all_zero("reset");
    reset = 1'b0;
    idle();
    tick();

    // Preload column 0 with 3 then 5; compute 10 + 2*5 then 20 + (-1)*3.
    io_in_b_shift[0] = 1'b1;
    set_b(0, 19'd3);
    tick();
    set_b(0, 19'd5);
    tick();
    idle();
    check("preload out_b0", 64'(io_out_b[0 +: B_W]), 64'd3);
    check("preload out_b1", 64'(io_out_b[B_W +: B_W]), 64'd0);
    drive_col(0, 1'b1, 1'b1, 32'd10, 5'd0);
    set_a(0, 8'd2);
    expect_c(0, 32'd17);
    tick();
    idle();
    set_a(1, 8'hFF);
    tick();
    idle();
    check("compute prop0", 64'(io_out_control_propagate[0]), 64'd1);
    tick();

    // Rounding shift on column 1 (zero weights pass d through).
    drive_col(1, 1'b1, 1'b0, 32'd17, 5'd2);
    expect_c(1, 32'd4);
    tick();
    drive_col(1, 1'b1, 1'b0, 32'hFFFF_FFFA, 5'd2);
    expect_c(1, 32'hFFFF_FFFF);
    tick();
    idle();
    tick();
    tick();
    io_in_b_shift[1] = 1'b1;
    set_b(1, 19'd1);
    tick();
    set_b(1, 19'd0);
    tick();
    idle();
    check("preload out_b1 one", 64'(io_out_b[B_W +: B_W]), 64'd1);
    drive_col(1, 1'b1, 1'b1, 32'h7FFF_FFFF, 5'd0);
    set_a(1, 8'd1);
    set_a(0, 8'h7F);
    expect_c(1, 32'h8000_0000);
    tick();
    idle();
    tick();
    tick();

    // Valid low for 5 cycles: results and control hold, activations keep moving.
    for (int i = 0; i < 5; i++) begin
      io_in_a                 = AT'($urandom());
      io_in_b                 = BT'({$urandom(), $urandom()});
      io_in_d                 = DT'({$urandom(), $urandom()});
      io_in_control_propagate = COLS'($urandom());
      io_in_control_shift     = ST'($urandom());
      hist[i]                 = io_in_a;
      tick();
      check("hold valid", 64'(io_out_valid), 64'd0);
      check("hold out_c", 64'(io_out_c), {32'h8000_0000, 32'd17});
      check("hold prop", 64'(io_out_control_propagate), 64'd3);
      check("hold shift", 64'(io_out_control_shift), 64'd0);
      if (i >= 1) check("hold out_a delay", 64'(io_out_a), 64'(hist[i-1]));
    end
    idle();
    tick();
    tick();

    // Flip and chain shift hit cell(0,0) together.
    io_in_b_shift[0] = 1'b1;
    set_b(0, 19'd9);
    tick();
    set_b(0, 19'd4);
    tick();
    idle();
    check("flipshift pre out_b0", 64'(io_out_b[0 +: B_W]), 64'd9);
    drive_col(0, 1'b1, 1'b0, 32'd0, 5'd0);
    io_in_b_shift[0] = 1'b1;
    set_b(0, 19'd6);
    set_a(0, 8'd1);
    expect_c(0, 32'd4);
    tick();
    idle();
    tick();
    check("flipshift out_b0 row1", 64'(io_out_b[0 +: B_W]), 64'd3);
    check("flipshift prop0", 64'(io_out_control_propagate[0]), 64'd0);
    io_in_b_shift[0] = 1'b1;
    tick();
    idle();
    check("flipshift new shadow", 64'(io_out_b[0 +: B_W]), 64'd6);

    // Reset with a valid in flight: nothing emerges, weights cleared.
    drive_col(1, 1'b1, 1'b1, 32'd5, 5'd0);
    set_a(0, 8'd3);
    tick();
    idle();
    reset = 1'b1;
    tick();
    check_all_zero("midreset");
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("post-reset valid", 64'(io_out_valid), 64'd0);
      check("post-reset out_b", 64'(io_out_b), 64'd0);
    end

    tick();
    check("drain col0", 64'(q0.size()), 64'd0);
    check("drain col1", 64'(q1.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
